au_neg_seq: RTL and testbench

Digit-serial 2's complementer with selectable sign operation (pass, negate, absolute, negative-absolute) and valid/ready handshakes on both sides. Processes DIGIT bits per cycle, LSB first, rippling the +1 carry between digits in a register. Sits beside the combinational negator in the arithmetic-unit library for area-constrained datapaths that can tolerate multi-cycle latency.

---
 rtl/au_neg_seq.sv | 124 ++++++++++++
 tb/tb_au_neg_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/au_neg_seq.sv
// Digit-serial 2's complementer: pass / negate / abs / nabs, DIGIT bits per cycle LSB first,
// with the +1 carry rippled between digits through a register.
module au_neg_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int NCYC = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_param_check
      $fatal(1, "au_neg_seq: illegal parameters WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic             neg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_digit;
  logic             neg_in;
  logic [31:0]      shamt;
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] z_slice;
  logic [DIGIT:0]   dsum;
  logic             carry_next;
  logic [WIDTH-1:0] z_next;

  assign accept     = in_valid & in_ready;
  assign last_digit = (cnt == CW'(NCYC - 1));
  assign neg_in     = (op == 2'd1) | ((op == 2'd2) & a[WIDTH-1]) | ((op == 2'd3) & ~a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_digit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Bits beyond WIDTH-1 in the final partial digit read as zero and are shifted out of z.
  always_comb begin
    shamt   = 32'(cnt) * 32'(DIGIT);
    a_slice = DIGIT'(a_reg >> shamt);
    dsum    = {1'b0, ~a_slice} + (DIGIT + 1)'(carry);
    if (neg) begin
      z_slice    = dsum[DIGIT-1:0];
      carry_next = dsum[DIGIT];
    end else begin
      z_slice    = a_slice;
      carry_next = carry;
    end
    z_next = z | (WIDTH'(z_slice) << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      neg   <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            neg   <= neg_in;
            carry <= neg_in;
            cnt   <= '0;
            z     <= '0;
            ovf   <= 1'b0;
          end
        end
        BUSY: begin
          z     <= z_next;
          carry <= carry_next;
          if (last_digit) begin
            cnt <= '0;
            ovf <= neg & a_reg[WIDTH-1] & z_next[WIDTH-1];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_neg_seq.sv
// Randomised and directed bench for au_neg_seq; results are compared with a signed-integer
// model of pass / -a / |a| / -|a| taken mod 2^WIDTH.
module tb_au_neg_seq;

  localparam int MAIN_NCYC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_r;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic       ovf;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  au_neg_seq #(.WIDTH(8), .DIGIT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .ovf(ovf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Signed value of a, apply the operation in plain integers, then wrap to w bits.
  function automatic void refModel(input logic [63:0] a_v, input logic [1:0] op_v, input int w,
                                   output logic [63:0] z_e, output logic ovf_e);
    longint sv, r, max_v, min_v;
    logic [63:0] mask;
    mask  = (64'd1 << w) - 64'd1;
    sv    = a_v[w-1] ? longint'(a_v) - (longint'(1) << w) : longint'(a_v);
    case (op_v)
      2'd0:    r = sv;
      2'd1:    r = -sv;
      2'd2:    r = (sv < 0) ? -sv : sv;
      default: r = (sv < 0) ? sv : -sv;
    endcase
    max_v = (longint'(1) << (w - 1)) - 1;
    min_v = -(longint'(1) << (w - 1));
    z_e   = 64'(r) & mask;
    ovf_e = (r > max_v) || (r < min_v);
  endfunction

  task automatic applyStimulus(input logic [7:0] a_v, input logic [1:0] op_v, input int hold);
    int guard;
    int lat;
    logic [63:0] z_e;
    logic ovf_e;
    a = a_v; op = op_v; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(MAIN_NCYC));
    refModel(64'(a_v), op_v, 8, z_e, ovf_e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    checkOutput($sformatf("z a=%02h op=%0d", a_v, op_v), 64'(z), z_e);
    checkOutput($sformatf("ovf a=%02h op=%0d", a_v, op_v), 64'(ovf), 64'(ovf_e));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_drop", 64'(out_valid), 64'd0);
  endtask

  // Extra widths run in parallel, each with its own DUT and random handshake gaps.
  for (genvar gi = 0; gi < 5; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 7 : (gi == 2) ? 8 : (gi == 3) ? 13 : 32;
    localparam int D = (gi == 0) ? 1 : (gi == 1) ? 7 : (gi == 2) ? 1 : (gi == 3) ? 4 : 5;
    localparam int N = (W + D - 1) / D;

    logic         iv, ir, ov, orr, oo_f;
    logic [W-1:0] aa, zz;
    logic [1:0]   oo;
    logic         done_flag = 1'b0;

    au_neg_seq #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(rst_r), .in_valid(iv), .in_ready(ir), .a(aa), .op(oo),
      .out_valid(ov), .out_ready(orr), .z(zz), .ovf(oo_f)
    );

    initial begin
      int guard;
      int lat;
      int gap;
      logic [63:0] z_e;
      logic ovf_e;
      iv = 1'b0; orr = 1'b0; aa = '0; oo = '0;
      @(posedge rst_r);
      @(posedge clk); #1;
      for (int t = 0; t < 40; t++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
        aa = W'($urandom);
        oo = 2'($urandom_range(0, 3));
        iv = 1'b1;
        guard = 0;
        while (!ir && guard < 50) begin
          @(posedge clk); #1;
          guard++;
        end
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 100) begin
          @(posedge clk); #1;
          lat++;
        end
        checkOutput($sformatf("cfg%0d_latency", gi), 64'(lat), 64'(N));
        refModel(64'(aa), oo, W, z_e, ovf_e);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
        checkOutput($sformatf("cfg%0d_z a=%0h op=%0d", gi, aa, oo), 64'(zz), z_e);
        checkOutput($sformatf("cfg%0d_ovf a=%0h op=%0d", gi, aa, oo), 64'(oo_f), 64'(ovf_e));
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0;
      end
      done_flag = 1'b1;
    end
  end

  initial begin
    int guard;
    logic all_done;
    rst_n = 1'b0; rst_r = 1'b0;
    in_valid = 1'b0; a = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_z", 64'(z), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1; rst_r = 1'b1;
    @(posedge clk); #1;

    applyStimulus(8'h05, 2'd1, 0);
    applyStimulus(8'h00, 2'd1, 1);
    applyStimulus(8'h80, 2'd1, 0);
    applyStimulus(8'h80, 2'd2, 0);
    applyStimulus(8'h80, 2'd3, 0);
    applyStimulus(8'h80, 2'd0, 0);
    applyStimulus(8'hF6, 2'd2, 0);
    applyStimulus(8'h0A, 2'd2, 0);
    applyStimulus(8'h0A, 2'd3, 0);
    applyStimulus(8'hF6, 2'd3, 0);

    // Backpressure: a second operand waits on in_valid while the first result is held.
    a = 8'h05; op = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h0A; op = 2'd1;
    repeat (MAIN_NCYC) @(posedge clk);
    #1;
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_z_hold", 64'(z), 64'h0FB);
      checkOutput("bp_ovf_hold", 64'(ovf), 64'd0);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_idle_out_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_second_accepted", 64'(in_ready), 64'd0);
    repeat (MAIN_NCYC) @(posedge clk);
    #1;
    checkOutput("bp_second_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_second_z", 64'(z), 64'h0F6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of BUSY must drop the partial result immediately.
    a = 8'h33; op = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_z", 64'(z), 64'd0);
    checkOutput("midreset_ovf", 64'(ovf), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'h33, 2'd1, 0);

    for (int t = 0; t < 30; t++) begin
      applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    guard = 0;
    all_done = 1'b0;
    while (!all_done && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      all_done = g_cfg[0].done_flag & g_cfg[1].done_flag & g_cfg[2].done_flag &
                 g_cfg[3].done_flag & g_cfg[4].done_flag;
    end
    checkOutput("cfg_all_done", 64'(all_done), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
